// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file family.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int ZERO_ADDR = 0;

    typedef logic [RF_DATA_W-1:0] reg_data_t;
    typedef logic [RF_ADDR_W-1:0] reg_addr_t;

    // True when the address names the hard-wired zero register and that feature is enabled.
    function automatic logic is_zero_addr(input logic [31:0] addr, input int zero_reg);
        return (zero_reg != 0) && (addr == 32'(ZERO_ADDR));
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/issue bus between the dual-issue pipeline and the register file.
interface regfile_mp_if import rf_pkg::*; #(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int N_RD   = 4,
    parameter int N_WR   = 2
) ();

    logic [N_WR-1:0]        we_i;
    logic [N_WR*ADDR_W-1:0] wa_i;
    logic [N_WR*DATA_W-1:0] wd_i;
    logic [N_RD*ADDR_W-1:0] ra_i;
    logic [N_RD*DATA_W-1:0] rd_o;
    logic [N_RD-1:0]        rpend_o;
    logic                   alloc_i;
    logic [ADDR_W-1:0]      alloc_addr_i;
    logic                   flush_i;

    modport master (
        output we_i, wa_i, wd_i, ra_i, alloc_i, alloc_addr_i, flush_i,
        input  rd_o, rpend_o
    );

    modport slave (
        input  we_i, wa_i, wd_i, ra_i, alloc_i, alloc_addr_i, flush_i,
        output rd_o, rpend_o
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set at issue, cleared at writeback, wiped on flush.
module regfile_scoreboard import rf_pkg::*; #(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int N_RD     = 4,
    parameter int N_WR     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [N_WR-1:0]        wen_i,
    input  logic [N_WR*ADDR_W-1:0] wa_i,
    input  logic                   alloc_i,
    input  logic [ADDR_W-1:0]      alloc_addr_i,
    input  logic                   flush_i,
    input  logic [N_RD*ADDR_W-1:0] ra_i,
    output logic [N_RD-1:0]        pend_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // Priority low to high: writeback clear, new producer set, flush.
    always_comb begin
        pend_d = pend_q;
        for (int k = 0; k < N_WR; k++) begin
            if (wen_i[k]) begin
                pend_d[wa_i[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (alloc_i) begin
            pend_d[alloc_addr_i] = 1'b1;
        end
        if (flush_i) begin
            pend_d = '0;
        end
        if (ZERO_REG != 0) begin
            pend_d[ZERO_ADDR] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        pend_o = '0;
        for (int j = 0; j < N_RD; j++) begin
            pend_o[j] = pend_q[ra_i[j*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, zero register and pending scoreboard.
module regfile_mp import rf_pkg::*; #(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int N_RD     = 4,
    parameter int N_WR     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    regfile_mp_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] wa [N_WR];
    logic [DATA_W-1:0] wd [N_WR];
    logic [ADDR_W-1:0] ra [N_RD];
    logic [N_WR-1:0]   wen;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] rd     [N_RD];
    logic [N_RD-1:0]   wr_hit;
    logic [N_RD-1:0]   pend_lk;

    // A write port is live only out of reset and when it does not target the zero register.
    for (genvar k = 0; k < N_WR; k++) begin : g_wport
        assign wa[k]  = bus.wa_i[k*ADDR_W +: ADDR_W];
        assign wd[k]  = bus.wd_i[k*DATA_W +: DATA_W];
        assign wen[k] = rst_n_i & bus.we_i[k] & ~is_zero_addr(32'(wa[k]), ZERO_REG);
    end

    for (genvar j = 0; j < N_RD; j++) begin : g_rport
        assign ra[j]                        = bus.ra_i[j*ADDR_W +: ADDR_W];
        assign bus.rd_o[j*DATA_W +: DATA_W] = rd[j];
        assign bus.rpend_o[j]               = rst_n_i & pend_lk[j] & ~wr_hit[j];
    end

    // Ascending port order: the highest-numbered port to the same register lands last.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < N_WR; k++) begin
            if (wen[k]) begin
                regs_d[wa[k]] = wd[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        wr_hit = '0;
        for (int j = 0; j < N_RD; j++) begin
            rd[j] = regs_q[ra[j]];
            for (int k = 0; k < N_WR; k++) begin
                if (wen[k] && (wa[k] == ra[j])) begin
                    rd[j]     = wd[k];
                    wr_hit[j] = 1'b1;
                end
            end
            if (is_zero_addr(32'(ra[j]), ZERO_REG) || !rst_n_i) begin
                rd[j] = '0;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .N_RD     (N_RD),
        .N_WR     (N_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .wen_i        (wen),
        .wa_i         (bus.wa_i),
        .alloc_i      (bus.alloc_i),
        .alloc_addr_i (bus.alloc_addr_i),
        .flush_i      (bus.flush_i),
        .ra_i         (bus.ra_i),
        .pend_o       (pend_lk)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp: stimulus queues expectations, a monitor checks them.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int NW = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .N_WR(NW)) bus ();

    regfile_mp #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .N_RD     (NR),
        .N_WR     (NW),
        .ZERO_REG (1)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int            exp_port_q [$];
    logic [DW-1:0] exp_data_q [$];
    logic          exp_pend_q [$];
    string         exp_name_q [$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic idle();
        bus.we_i         = '0;
        bus.wa_i         = '0;
        bus.wd_i         = '0;
        bus.alloc_i      = 1'b0;
        bus.alloc_addr_i = '0;
        bus.flush_i      = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input int k, input int a, input logic [DW-1:0] d);
        bus.we_i[k]            = 1'b1;
        bus.wa_i[k*AW +: AW]   = AW'(a);
        bus.wd_i[k*DW +: DW]   = d;
    endtask

    task automatic alloc(input int a);
        bus.alloc_i      = 1'b1;
        bus.alloc_addr_i = AW'(a);
    endtask

    task automatic expect_rd(input int j, input int a, input logic [DW-1:0] d,
                             input logic p, input string nm);
        bus.ra_i[j*AW +: AW] = AW'(a);
        exp_port_q.push_back(j);
        exp_data_q.push_back(d);
        exp_pend_q.push_back(p);
        exp_name_q.push_back(nm);
    endtask

    // Outputs are combinational; sample them on the falling edge, away from state updates.
    always @(negedge clk) begin : monitor
        int            p;
        logic [DW-1:0] ed;
        logic          ep;
        string         nm;
        logic [DW-1:0] ad;
        logic          ap;
        while (exp_port_q.size() != 0) begin
            p  = exp_port_q.pop_front();
            ed = exp_data_q.pop_front();
            ep = exp_pend_q.pop_front();
            nm = exp_name_q.pop_front();
            ad = bus.rd_o[p*DW +: DW];
            ap = bus.rpend_o[p];
            n_chk++;
            if (ad !== ed || ap !== ep) begin
                n_fail++;
                $display("FAIL %s port %0d: rd=%h rpend=%b, expected rd=%h rpend=%b",
                         nm, p, ad, ap, ed, ep);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        bus.ra_i = '0;
        idle();

        // Reset state
        next_cycle();
        for (int j = 0; j < NR; j++) expect_rd(j, 5, 32'h0, 1'b0, "reset_state");
        next_cycle();
        rst_n = 1'b1;

        // Write x5 with a same-cycle alloc, then assert reset mid-cycle
        next_cycle();
        wr(0, 5, 32'hDEADBEEF);
        alloc(5);
        expect_rd(0, 5, 32'hDEADBEEF, 1'b0, "bypass_x5");
        next_cycle();
        expect_rd(0, 5, 32'hDEADBEEF, 1'b1, "array_x5_pending");
        next_cycle();
        rst_n = 1'b0;
        wr(1, 5, 32'h12345678);
        expect_rd(0, 5, 32'h0, 1'b0, "reset_clears_x5");
        expect_rd(1, 5, 32'h0, 1'b0, "reset_no_bypass");
        next_cycle();
        rst_n = 1'b1;
        expect_rd(0, 5, 32'h0, 1'b0, "reset_write_lost");

        // Dual write to the same register: port 1 wins
        next_cycle();
        wr(0, 7, 32'h11);
        wr(1, 7, 32'h22);
        for (int j = 0; j < NR; j++) expect_rd(j, 7, 32'h22, 1'b0, "dual_wr_bypass");
        next_cycle();
        expect_rd(1, 7, 32'h22, 1'b0, "dual_wr_array");

        // Bypass on all read ports
        next_cycle();
        wr(0, 3, 32'hA5A5A5A5);
        for (int j = 0; j < NR; j++) expect_rd(j, 3, 32'hA5A5A5A5, 1'b0, "bypass_all");

        // Two writes to different registers, each bypassed to its own readers
        next_cycle();
        wr(0, 3, 32'h33333333);
        wr(1, 4, 32'h44444444);
        expect_rd(0, 3, 32'h33333333, 1'b0, "bypass_port0_x3");
        expect_rd(1, 4, 32'h44444444, 1'b0, "bypass_port1_x4");
        expect_rd(2, 7, 32'h22,       1'b0, "array_x7");
        expect_rd(3, 3, 32'h33333333, 1'b0, "bypass_port0_x3_dup");
        next_cycle();
        expect_rd(0, 3, 32'h33333333, 1'b0, "array_x3");
        expect_rd(1, 4, 32'h44444444, 1'b0, "array_x4");

        // Zero register ignores writes and allocations
        next_cycle();
        wr(1, 0, 32'hFFFFFFFF);
        alloc(0);
        expect_rd(0, 0, 32'h0, 1'b0, "zero_same_cycle");
        next_cycle();
        expect_rd(0, 0, 32'h0, 1'b0, "zero_after_edge");

        // Scoreboard set / clear / collision
        next_cycle();
        alloc(9);
        expect_rd(0, 9, 32'h0, 1'b0, "alloc_x9_same_cycle");
        next_cycle();
        expect_rd(0, 9, 32'h0, 1'b1, "alloc_x9_pending");
        next_cycle();
        wr(0, 9, 32'h99);
        alloc(9);
        expect_rd(0, 9, 32'h99, 1'b0, "wr_alloc_x9_bypass");
        next_cycle();
        expect_rd(0, 9, 32'h99, 1'b1, "wr_alloc_x9_stays_pending");
        next_cycle();
        wr(1, 9, 32'h9A);
        expect_rd(0, 9, 32'h9A, 1'b0, "wb_x9_bypass");
        next_cycle();
        expect_rd(0, 9, 32'h9A, 1'b0, "wb_x9_cleared");

        // Flush overrides pending bits and a same-cycle alloc
        next_cycle();
        alloc(1);
        next_cycle();
        alloc(2);
        expect_rd(0, 1, 32'h0, 1'b1, "pend_x1_early");
        next_cycle();
        alloc(3);
        next_cycle();
        alloc(4);
        next_cycle();
        bus.flush_i = 1'b1;
        alloc(6);
        expect_rd(0, 1, 32'h0,        1'b1, "pend_x1");
        expect_rd(1, 2, 32'h0,        1'b1, "pend_x2");
        expect_rd(2, 3, 32'h33333333, 1'b1, "pend_x3");
        expect_rd(3, 4, 32'h44444444, 1'b1, "pend_x4");
        next_cycle();
        expect_rd(0, 1, 32'h0,        1'b0, "flush_x1");
        expect_rd(1, 2, 32'h0,        1'b0, "flush_x2");
        expect_rd(2, 3, 32'h33333333, 1'b0, "flush_x3");
        expect_rd(3, 6, 32'h0,        1'b0, "flush_over_alloc_x6");
        next_cycle();
        expect_rd(0, 4, 32'h44444444, 1'b0, "flush_x4");

        next_cycle();
        next_cycle();
        n_chk++;
        if (exp_port_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_port_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
